// File: rtl/reg_op_sequencer.sv
// Register-op sequencer: steps one instruction through register-file reads, execute and
// write-back, then pulses done. Only CMP updates the Z/N/V flags.
module reg_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rn,
  input  logic [2:0]       in_rm,
  input  logic [IMM_W-1:0] in_imm,
  output logic [2:0]       rf_readnum,
  input  logic [WIDTH-1:0] rf_data_out,
  output logic [2:0]       rf_writenum,
  output logic             rf_write,
  output logic [WIDTH-1:0] rf_data_in,
  output logic             done,
  output logic             illegal,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag
);

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_MVN  = 3'd4;
  localparam logic [2:0] OP_CMP  = 3'd5;

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t state, state_next;

  logic [2:0]       op_q, rd_q, rn_q, rm_q;
  logic [WIDTH-1:0] a, b, c;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] imm_ext;
  logic             accept;
  logic             done_next, illegal_next;

  assign imm_ext = {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign diff    = a - b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_next;
  end

  // Every handshake and register-file control output is decoded from state alone,
  // so an asynchronous reset removes rf_write immediately.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    in_ready     = 1'b0;
    rf_readnum   = 3'd0;
    rf_write     = 1'b0;
    case (state)
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          case (in_op)
            OP_MOVI:                state_next = S_WRITE;
            OP_MOV, OP_MVN:         state_next = S_LOAD_B;
            OP_ADD, OP_AND, OP_CMP: state_next = S_LOAD_A;
            default: begin
              state_next   = S_WAIT;
              done_next    = 1'b1;
              illegal_next = 1'b1;
            end
          endcase
        end
      end
      S_LOAD_A: begin
        rf_readnum = rn_q;
        state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        rf_readnum = rm_q;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_CMP) begin
          state_next = S_WAIT;
          done_next  = 1'b1;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        rf_write   = 1'b1;
        state_next = S_WAIT;
        done_next  = 1'b1;
      end
      default: state_next = S_WAIT;
    endcase
  end

  assign rf_writenum = rd_q;
  assign rf_data_in  = c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= done_next;
      illegal <= illegal_next;
    end
  end

  // Instruction fields are held for the whole operation; MOVI loads C at accept time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 3'd0;
      rd_q <= 3'd0;
      rn_q <= 3'd0;
      rm_q <= 3'd0;
    end else if (accept) begin
      op_q <= in_op;
      rd_q <= in_rd;
      rn_q <= in_rn;
      rm_q <= in_rm;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a <= '0;
      b <= '0;
    end else begin
      if (state == S_LOAD_A) a <= rf_data_out;
      if (state == S_LOAD_B) b <= rf_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c <= '0;
    end else if (accept && in_op == OP_MOVI) begin
      c <= imm_ext;
    end else if (state == S_EXEC) begin
      case (op_q)
        OP_MOV:  c <= b;
        OP_ADD:  c <= a + b;
        OP_AND:  c <= a & b;
        OP_MVN:  c <= ~b;
        default: c <= c;
      endcase
    end
  end

  // Overflow of A-B: operands differ in sign and the result sign differs from A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      v_flag <= 1'b0;
    end else if (state == S_EXEC && op_q == OP_CMP) begin
      z_flag <= (diff == '0);
      n_flag <= diff[WIDTH-1];
      v_flag <= (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule
